tx_queue: RTL

- AXI-Stream to MAC converter, TX side. Accepts 64-bit AXI-Stream packets from the datapath and buffers each packet whole (store-and-forward) in an internal FIFO.
- Replays each buffered packet to the 10G MAC client TX interface with a start/ack handshake, so the MAC never sees a mid-frame bubble (underrun).
- Single clock domain; sits in the MAC clock domain downstream of any clock-crossing logic.

---
 rtl/tx_queue.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tx_queue.sv
// tx_queue: store-and-forward bridge from a 64-bit AXI-Stream to a 10G MAC TX client.
// A packet is replayed to the MAC only after all of its beats are in the buffer, so a frame never stalls.
module tx_queue #(
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int FIFO_ADDR_WIDTH = 9
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [AXI_DATA_WIDTH-1:0]   tdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] tstrb,
    input  logic                        tvalid,
    input  logic                        tlast,
    output logic                        tready,
    output logic [AXI_DATA_WIDTH-1:0]   tx_data,
    output logic [AXI_DATA_WIDTH/8-1:0] tx_data_valid,
    output logic                        tx_start,
    input  logic                        tx_ack,
    output logic                        pkt_drop
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;
    localparam int PTR_W  = FIFO_ADDR_WIDTH + 1;

    typedef enum logic {W_ACCEPT, W_DROP} wstate_t;
    typedef enum logic [1:0] {IDLE, WAIT_ACK, SEND, IFG} rstate_t;

    logic [STRB_W+AXI_DATA_WIDTH-1:0] word_mem [DEPTH];
    logic [DEPTH-1:0]                 last_mem;
    logic [STRB_W+AXI_DATA_WIDTH-1:0] head;

    logic [PTR_W-1:0]           wr_ptr, wr_ptr_inc, rd_ptr, commit_ptr, pkt_count;
    logic [FIFO_ADDR_WIDTH-1:0] wr_addr, rd_addr, tail_addr;
    wstate_t                    wstate;
    rstate_t                    rstate;
    logic                       ready_en, full, accept, in_accept;
    logic                       do_write, do_tail_last, commit, do_drop, rd_done, cur_last;

    assign wr_addr    = wr_ptr[FIFO_ADDR_WIDTH-1:0];
    assign rd_addr    = rd_ptr[FIFO_ADDR_WIDTH-1:0];
    assign tail_addr  = wr_addr - FIFO_ADDR_WIDTH'(1);
    assign wr_ptr_inc = wr_ptr + PTR_W'(1);

    // One slot is kept free so full is visible from the address bits alone.
    assign full      = (wr_ptr_inc[FIFO_ADDR_WIDTH-1:0] == rd_addr);
    assign in_accept = (wstate == W_ACCEPT);
    assign tready    = ready_en & (~in_accept | ~full);
    assign accept    = tvalid & tready;

    assign do_write     = accept & in_accept & (tstrb != '0);
    assign do_tail_last = accept & in_accept & tlast & (tstrb == '0) & (wr_ptr != commit_ptr);
    assign commit       = (do_write & tlast) | do_tail_last;
    assign do_drop      = in_accept & full & (pkt_count == '0);

    assign rd_done = ((rstate == WAIT_ACK) & tx_ack & cur_last) | ((rstate == SEND) & cur_last);
    assign head    = word_mem[rd_addr];

    // Buffer storage: payload and strobes, plus a separately writable end-of-packet flag.
    always_ff @(posedge clk) begin
        if (do_write) begin
            word_mem[wr_addr] <= {tstrb, tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            last_mem[wr_addr] <= tlast;
        end else if (do_tail_last) begin
            last_mem[tail_addr] <= 1'b1;
        end
    end

    // Write side: accept, commit on tlast, or discard a packet that can never fit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wstate     <= W_ACCEPT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            pkt_drop   <= 1'b0;
            ready_en   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            pkt_drop <= 1'b0;
            case (wstate)
                W_ACCEPT: begin
                    if (do_drop) begin
                        wr_ptr   <= commit_ptr;
                        wstate   <= W_DROP;
                        pkt_drop <= 1'b1;
                    end else begin
                        if (do_write) begin
                            wr_ptr <= wr_ptr_inc;
                        end
                        if (do_write && tlast) begin
                            commit_ptr <= wr_ptr_inc;
                        end else if (do_tail_last) begin
                            commit_ptr <= wr_ptr;
                        end
                    end
                end
                W_DROP: begin
                    if (accept && tlast) begin
                        wstate <= W_ACCEPT;
                    end
                end
                default: wstate <= W_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count <= '0;
        end else if (commit && !rd_done) begin
            pkt_count <= pkt_count + PTR_W'(1);
        end else if (!commit && rd_done) begin
            pkt_count <= pkt_count - PTR_W'(1);
        end
    end

    // Read side: present head word with tx_start, then stream the rest back-to-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstate        <= IDLE;
            rd_ptr        <= '0;
            tx_data       <= '0;
            tx_data_valid <= '0;
            tx_start      <= 1'b0;
            cur_last      <= 1'b0;
        end else begin
            case (rstate)
                IDLE: begin
                    if (pkt_count != '0) begin
                        tx_data       <= head[AXI_DATA_WIDTH-1:0];
                        tx_data_valid <= head[STRB_W+AXI_DATA_WIDTH-1:AXI_DATA_WIDTH];
                        cur_last      <= last_mem[rd_addr];
                        tx_start      <= 1'b1;
                        rd_ptr        <= rd_ptr + PTR_W'(1);
                        rstate        <= WAIT_ACK;
                    end
                end
                WAIT_ACK, SEND: begin
                    if (rstate == SEND || tx_ack) begin
                        tx_start <= 1'b0;
                        if (cur_last) begin
                            tx_data       <= '0;
                            tx_data_valid <= '0;
                            rstate        <= IFG;
                        end else begin
                            tx_data       <= head[AXI_DATA_WIDTH-1:0];
                            tx_data_valid <= head[STRB_W+AXI_DATA_WIDTH-1:AXI_DATA_WIDTH];
                            cur_last      <= last_mem[rd_addr];
                            rd_ptr        <= rd_ptr + PTR_W'(1);
                            rstate        <= SEND;
                        end
                    end
                end
                IFG: rstate <= IDLE;
                default: rstate <= IDLE;
            endcase
        end
    end
endmodule
